// File: rtl/mc_maindec.sv
// ---------------------------------------------------------------------------
// mc_maindec -- multicycle main control FSM for the MIPS datapath.
//
// Sequences each instruction through fetch / decode / execute / memory /
// writeback states and drives the datapath enables and mux selects.  Memory
// states (FETCH, MEMRD, MEMWR) stall on the mem_ready_i handshake.
//
// Configuration macro: MC_MAINDEC_JUMP_EN
//   defined   : opcode 000010 (j) decodes to the JUMP state.
//   undefined : opcode 000010 is illegal; JUMP (encoding 11) is unreachable.
//
// Parameters:
//   ALUOP_W  : width of aluop_o (values 00/01/10 only, upper bits zero).
//   WAIT_MEM : 1 = memory states wait on mem_ready_i, 0 = mem_ready_i ignored.
//
// Ports:
//   clk_i, reset_i     : clock (rising edge), asynchronous active-high reset
//   op_i               : opcode instr[31:26], used in DECODE and MEMADR only
//   mem_ready_i        : memory has completed the current access
//   pcwrite_o/branch_o : unconditional / zero-conditional PC write
//   irwrite_o          : instruction register load
//   memwrite_o         : memory write strobe
//   iord_o             : memory address select (0 PC, 1 ALUOut)
//   regwrite_o         : register file write
//   regdst_o           : write register select (1 rd, 0 rt)
//   memtoreg_o         : writeback select (1 data reg, 0 ALUOut)
//   alusrca_o          : ALU A select (0 PC, 1 A)
//   alusrcb_o          : ALU B select (00 B, 01 4, 10 SignImm, 11 SignImm<<2)
//   pcsrc_o            : PC source (00 ALUResult, 01 ALUOut, 10 jump target)
//   aluop_o            : ALU decoder mode
//   illegal_op_o       : one-cycle pulse in DECODE on an unsupported opcode
//   state_o            : current state encoding (debug)
// ---------------------------------------------------------------------------
module mc_maindec #(
  parameter int ALUOP_W  = 2,
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [5:0]         op_i,
  input  logic               mem_ready_i,
  output logic               pcwrite_o,
  output logic               branch_o,
  output logic               irwrite_o,
  output logic               memwrite_o,
  output logic               iord_o,
  output logic               regwrite_o,
  output logic               regdst_o,
  output logic               memtoreg_o,
  output logic               alusrca_o,
  output logic [1:0]         alusrcb_o,
  output logic [1:0]         pcsrc_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               illegal_op_o,
  output logic [3:0]         state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Moore control word. mem_gate marks the state whose pcwrite/irwrite are
  // qualified by mem_ready (FETCH only).
  typedef struct packed {
    logic       mem_gate;
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       memwrite;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.mem_gate = 1'b1; c.pcwrite = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      S_ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BRANCH:  begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl_out;
  logic   illegal_d;
  logic   mem_rdy;

  assign mem_rdy = WAIT_MEM ? mem_ready_i : 1'b1;

  // Next-state logic; illegal_d is only ever raised in DECODE.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_MAINDEC_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXECUTE: state_d = S_ALUWB;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;  // MEMWB, ALUWB, ADDIWB and unused codes
    endcase
  end

  // State and control word are registered together; the control word is
  // precomputed from the next state so it lines up with state_q.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  // FETCH write enables follow mem_ready; reset masks everything at once so
  // no enable can fire after reset rises, even before the next edge.
  always_comb begin
    ctrl_out = ctrl_q;
    if (ctrl_q.mem_gate && !mem_rdy) begin
      ctrl_out.pcwrite = 1'b0;
      ctrl_out.irwrite = 1'b0;
    end
    if (reset_i) begin
      ctrl_out = '0;
    end
  end

  assign pcwrite_o    = ctrl_out.pcwrite;
  assign branch_o     = ctrl_out.branch;
  assign irwrite_o    = ctrl_out.irwrite;
  assign memwrite_o   = ctrl_out.memwrite;
  assign iord_o       = ctrl_out.iord;
  assign regwrite_o   = ctrl_out.regwrite;
  assign regdst_o     = ctrl_out.regdst;
  assign memtoreg_o   = ctrl_out.memtoreg;
  assign alusrca_o    = ctrl_out.alusrca;
  assign alusrcb_o    = ctrl_out.alusrcb;
  assign pcsrc_o      = ctrl_out.pcsrc;
  assign aluop_o      = ALUOP_W'(ctrl_out.aluop);
  assign illegal_op_o = illegal_d & ~reset_i;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mc_maindec.sv
// ---------------------------------------------------------------------------
// tb_mc_maindec -- self-checking bench for mc_maindec.
// Table of per-opcode state sequences, hand-written multicycle corner cases
// (memory wait, illegal opcode, reset mid-instruction) and randomized
// instructions with random wait states checked against an instruction-level
// model that expands each opcode into its expected list of cycles.
// ---------------------------------------------------------------------------
module tb_mc_maindec;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_MAINDEC_JUMP_EN
  localparam bit JUMP_EN = 1'b1;
`else
  localparam bit JUMP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic       illegal_op;
  logic [3:0] state;
  logic [14:0] dut_outs;

  always #5 clk = ~clk;

  mc_maindec dut (
    .clk_i(clk), .reset_i(reset), .op_i(op), .mem_ready_i(mem_ready),
    .pcwrite_o(pcwrite), .branch_o(branch), .irwrite_o(irwrite),
    .memwrite_o(memwrite), .iord_o(iord), .regwrite_o(regwrite),
    .regdst_o(regdst), .memtoreg_o(memtoreg), .alusrca_o(alusrca),
    .alusrcb_o(alusrcb), .pcsrc_o(pcsrc), .aluop_o(aluop),
    .illegal_op_o(illegal_op), .state_o(state)
  );

  assign dut_outs = {pcwrite, branch, irwrite, memwrite, iord, regwrite, regdst,
                     memtoreg, alusrca, alusrcb, pcsrc, aluop};

  typedef struct packed {
    logic pcwrite, branch, irwrite, memwrite, iord, regwrite, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
  } outs_t;

  typedef struct {
    int         st;
    logic       mr;
    logic [5:0] op;
    logic       ill;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         n;
    int         seq[5];
    logic       ill;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int mw_cnt, wr_cnt, ill_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Expected control outputs for a state, straight from the state table.
  function automatic logic [14:0] exp_outs(input int st, input logic mr);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcwrite = mr; end
      1:  o.alusrcb = 2'b11;
      2:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      3:  o.iord = 1'b1;
      4:  begin o.regwrite = 1'b1; o.memtoreg = 1'b1; end
      5:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      6:  begin o.alusrca = 1'b1; o.aluop = 2'b10; end
      7:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      8:  begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.branch = 1'b1; end
      9:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
      10: o.regwrite = 1'b1;
      11: begin o.pcsrc = 2'b10; o.pcwrite = 1'b1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  function automatic logic is_legal(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ) ||
           (o == OP_ADDI) || (JUMP_EN && (o == OP_J));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic rmr();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic step_t mk_step(input int st, input logic mr, input logic [5:0] o, input logic ill);
    step_t s;
    s.st = st; s.mr = mr; s.op = o; s.ill = ill;
    return s;
  endfunction

  function automatic vec_t mk_vec(input logic [5:0] o, input int n, input int s0, input int s1,
                                  input int s2, input int s3, input int s4, input logic ill);
    vec_t v;
    v.op = o; v.n = n; v.ill = ill;
    v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
    return v;
  endfunction

  // One clock cycle: called in the low phase, drives inputs, checks, then
  // waits for the next falling edge.
  task automatic step(input logic [5:0] o, input logic mr, input int exp_st,
                      input logic exp_ill, input string tag);
    op = o;
    mem_ready = mr;
    #1;
    chk({tag, " state"}, int'(state), exp_st);
    chk({tag, " outs"}, int'(dut_outs), int'(exp_outs(exp_st, mr)));
    chk({tag, " illegal_op"}, int'(illegal_op), int'(exp_ill));
    if (memwrite === 1'b1) mw_cnt++;
    if (regwrite === 1'b1) wr_cnt++;
    if (illegal_op === 1'b1) ill_cnt++;
    @(negedge clk);
  endtask

  // Instruction-level model: expand an opcode into its cycle list, with
  // wf FETCH waits and wm waits in the memory access state.
  task automatic run_instr(input logic [5:0] o, input int wf, input int wm, input int idx);
    step_t q[$];
    for (int i = 0; i < wf; i++) q.push_back(mk_step(0, 1'b0, rop(), 1'b0));
    q.push_back(mk_step(0, 1'b1, rop(), 1'b0));
    q.push_back(mk_step(1, rmr(), o, !is_legal(o)));
    if (o == OP_LW || o == OP_SW) begin
      q.push_back(mk_step(2, rmr(), o, 1'b0));
      for (int i = 0; i < wm; i++) q.push_back(mk_step((o == OP_LW) ? 3 : 5, 1'b0, rop(), 1'b0));
      q.push_back(mk_step((o == OP_LW) ? 3 : 5, 1'b1, rop(), 1'b0));
      if (o == OP_LW) q.push_back(mk_step(4, rmr(), rop(), 1'b0));
    end else if (o == OP_R) begin
      q.push_back(mk_step(6, rmr(), rop(), 1'b0));
      q.push_back(mk_step(7, rmr(), rop(), 1'b0));
    end else if (o == OP_BEQ) begin
      q.push_back(mk_step(8, rmr(), rop(), 1'b0));
    end else if (o == OP_ADDI) begin
      q.push_back(mk_step(9, rmr(), rop(), 1'b0));
      q.push_back(mk_step(10, rmr(), rop(), 1'b0));
    end else if (o == OP_J && JUMP_EN) begin
      q.push_back(mk_step(11, rmr(), rop(), 1'b0));
    end
    foreach (q[i]) step(q[i].op, q[i].mr, q[i].st, q[i].ill, $sformatf("rnd%0d.c%0d", idx, i));
    $display("rand instr %0d: op=%b wf=%0d wm=%0d cycles=%0d", idx, o, wf, wm, q.size());
  endtask

  vec_t tbl[7];

  initial begin
    tbl[0] = mk_vec(OP_R,    4, 0, 1, 6, 7, 0, 1'b0);
    tbl[1] = mk_vec(OP_LW,   5, 0, 1, 2, 3, 4, 1'b0);
    tbl[2] = mk_vec(OP_SW,   4, 0, 1, 2, 5, 0, 1'b0);
    tbl[3] = mk_vec(OP_BEQ,  3, 0, 1, 8, 0, 0, 1'b0);
    tbl[4] = mk_vec(OP_ADDI, 4, 0, 1, 9, 10, 0, 1'b0);
    if (JUMP_EN) tbl[5] = mk_vec(OP_J, 3, 0, 1, 11, 0, 0, 1'b0);
    else         tbl[5] = mk_vec(OP_J, 2, 0, 1, 0, 0, 0, 1'b1);
    tbl[6] = mk_vec(6'b111111, 2, 0, 1, 0, 0, 0, 1'b1);

    // Reset held for 3 cycles.
    reset = 1'b1; op = '0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("reset state", int'(state), 0);
      chk("reset outs", int'(dut_outs), 0);
      chk("reset illegal_op", int'(illegal_op), 0);
    end
    reset = 1'b0;
    $display("reset released");

    // Table: zero-wait state sequences; the next entry's first check
    // confirms the return to FETCH, which pins the cycle count.
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < tbl[v].n; c++)
        step(tbl[v].op, 1'b1, tbl[v].seq[c], (c == 1) && tbl[v].ill, $sformatf("tbl%0d.c%0d", v, c));
      $display("table vec %0d: op=%b cycles=%0d", v, tbl[v].op, tbl[v].n);
    end

    // sw with two wait cycles in MEMWR.
    mw_cnt = 0;
    step(OP_SW, 1'b1, 0, 1'b0, "sw.fetch");
    step(OP_SW, 1'b1, 1, 1'b0, "sw.decode");
    step(OP_SW, 1'b1, 2, 1'b0, "sw.memadr");
    step(OP_SW, 1'b0, 5, 1'b0, "sw.wait0");
    step(OP_SW, 1'b0, 5, 1'b0, "sw.wait1");
    step(OP_SW, 1'b1, 5, 1'b0, "sw.done");
    chk("sw memwrite cycles", mw_cnt, 3);
    $display("sw wait sequence: memwrite cycles=%0d", mw_cnt);

    // Illegal opcode: single pulse, no writes.
    ill_cnt = 0; wr_cnt = 0; mw_cnt = 0;
    step(6'b111111, 1'b1, 0, 1'b0, "ill.fetch");
    step(6'b111111, 1'b1, 1, 1'b1, "ill.decode");
    step(6'b111111, 1'b0, 0, 1'b0, "ill.back");
    chk("illegal pulse count", ill_cnt, 1);
    chk("illegal writes", wr_cnt + mw_cnt, 0);
    $display("illegal op sequence: pulses=%0d", ill_cnt);

    // Reset asserted mid-lw while stalled in MEMRD.
    step(OP_LW, 1'b1, 0, 1'b0, "mr.fetch");
    step(OP_LW, 1'b1, 1, 1'b0, "mr.decode");
    step(OP_LW, 1'b1, 2, 1'b0, "mr.memadr");
    op = OP_LW; mem_ready = 1'b0; #1;
    chk("midrst pre state", int'(state), 3);
    reset = 1'b1; #1;
    chk("midrst state", int'(state), 0);
    chk("midrst outs", int'(dut_outs), 0);
    mem_ready = 1'b1;
    @(negedge clk); #1;
    chk("midrst hold state", int'(state), 0);
    chk("midrst hold outs", int'(dut_outs), 0);
    reset = 1'b0;
    $display("mid-instruction reset done");

    // Randomized instructions with random wait states.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] o;
      case ($urandom_range(0, 6))
        0: o = OP_R;
        1: o = OP_LW;
        2: o = OP_SW;
        3: o = OP_BEQ;
        4: o = OP_ADDI;
        5: o = OP_J;
        default: begin
          o = rop();
          while (is_legal(o)) o = rop();
        end
      endcase
      run_instr(o, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete (checks %0d)", checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main control FSM for the MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives the datapath enables and mux selects from the current state. It supports memory that takes a variable number of cycles, using a `mem_ready` handshake. It replaces the single-cycle opcode decoder when the core is built as a shared-memory multicycle machine, and sits between the instruction register opcode field and the datapath.

## Interface
Parameters:
- `ALUOP_W`, default 2: width of `aluop`, passed to the ALU decoder. Only values 00, 01 and 10 are ever driven; any upper bits are 0.
- `WAIT_MEM`, default 1: 1 means memory states wait on `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `op`  in  6: opcode, `instr[31:26]`, sampled in DECODE.
- `mem_ready`  in  1: memory has completed the current access.
- `pcwrite`  out  1: unconditional PC write.
- `branch`  out  1: PC write when zero.
- `irwrite`  out  1: instruction register load.
- `memwrite`  out  1: memory write strobe.
- `iord`  out  1: 0 = PC address, 1 = ALUOut address.
- `regwrite`  out  1: register file write.
- `regdst`  out  1: 1 = rd, 0 = rt.
- `memtoreg`  out  1: 1 = data register, 0 = ALUOut.
- `alusrca`  out  1: 0 = PC, 1 = A.
- `alusrcb`  out  2: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- `pcsrc`  out  2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop`  out  `ALUOP_W`: ALU decoder mode.
- `illegal_op`  out  1: one-cycle pulse on an unsupported opcode.
- `state`  out  4: current state encoding, for debug.

## Operation
- Outputs are Moore: a function of the state only, except the `mem_ready` gating listed below. Any output not listed for a state is 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- FETCH:
  - Outputs: `alusrcb`=01; `irwrite`=`pcwrite`=`mem_ready`.
  - Transition: to DECODE when `mem_ready`, otherwise stay.
- DECODE:
  - Outputs: `alusrcb`=11.
  - Transitions: 100011 or 101011 → MEMADR; 000000 → EXECUTE; 000100 → BRANCH; 001000 → ADDIEX; 000010 → JUMP (only when `JUMP_EN` is defined).
  - Any other opcode → FETCH, with `illegal_op`=1 for that DECODE cycle.
- MEMADR:
  - Outputs: `alusrca`=1, `alusrcb`=10.
  - Transitions: `op`=100011 → MEMRD, otherwise MEMWR.
- MEMRD:
  - Outputs: `iord`=1.
  - Transition: to MEMWB when `mem_ready`, otherwise stay.
- MEMWB:
  - Outputs: `regwrite`=1, `memtoreg`=1.
  - Transition: → FETCH.
- MEMWR:
  - Outputs: `iord`=1, `memwrite`=1 (held while waiting).
  - Transition: to FETCH when `mem_ready`.
- EXECUTE:
  - Outputs: `alusrca`=1, `aluop`=10.
  - Transition: → ALUWB.
- ALUWB:
  - Outputs: `regdst`=1, `regwrite`=1.
  - Transition: → FETCH.
- BRANCH:
  - Outputs: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - Transition: → FETCH.
- ADDIEX:
  - Outputs: `alusrca`=1, `alusrcb`=10.
  - Transition: → ADDIWB.
- ADDIWB:
  - Outputs: `regwrite`=1.
  - Transition: → FETCH.
- JUMP:
  - Outputs: `pcsrc`=10, `pcwrite`=1.
  - Transition: → FETCH.
- Unused encodings 12–15 → FETCH on the next edge. All outputs are 0 while in them.

## Timing
- Reset:
  - `state`=FETCH immediately on assertion.
  - While `reset`=1, `pcwrite`, `irwrite`, `memwrite`, `regwrite`, `branch` and `illegal_op` are forced to 0, and all selects are 0.
  - Reset asserted mid-instruction aborts it; no write enable is asserted after reset rises.
- Cycle counts with zero wait states, fetch to the next fetch:
  - R-type: 4.
  - lw: 5.
  - sw: 4.
  - beq: 3.
  - addi: 4.
  - j: 3.
- Each cycle with `mem_ready` low in FETCH, MEMRD or MEMWR adds exactly one cycle. No other state is affected by `mem_ready`.
- `op` is sampled only in DECODE and MEMADR. `op` changing in any other state has no effect.

## Configuration
- `MC_MAINDEC_JUMP_EN` defined: opcode 000010 decodes to JUMP.
- Not defined: opcode 000010 is illegal (→ FETCH with an `illegal_op` pulse), and the JUMP state encoding 11 is unreachable.

## Test plan
- Reset held 3 cycles, `mem_ready`=1:
  - During reset, `state`=0 and all enables are 0.
  - After release, the first edge gives `state`=1.
- lw (`op`=100011), `mem_ready`=1:
  - States run 0,1,2,3,4,0.
  - `regwrite` and `memtoreg` are 1 only in state 4.
- sw with `mem_ready` low for 2 cycles in MEMWR:
  - `memwrite`=1 for 3 consecutive cycles.
  - Then `state`=0.
- beq (`op`=000100):
  - States run 0,1,8,0.
  - In state 8: `branch`=1, `pcsrc`=01, `aluop`=01.
- `op`=111111 in DECODE:
  - `illegal_op` pulses for 1 cycle, then `state`=0.
  - No `regwrite` or `memwrite` occurs.
- j (`op`=000010):
  - With the macro defined: states run 0,1,11,0, with `pcwrite`=1 and `pcsrc`=10 in state 11.
  - Without the macro: `illegal_op` pulses.
